// File: rtl/watch_pkg.sv
// Shared watch datapath types and defaults.
// Used by the seconds counter and the future minute counter.
package watch_pkg;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int SEC_W      = 8;
   localparam int CLK_HZ_DEF = 50_000_000;
   localparam int MAX_SEC    = 59;

   // Wrapping increment: at or above the top value the count returns to 0.
   function automatic logic [SEC_W-1:0] sec_next(
      input logic [SEC_W-1:0] cur,
      input logic [SEC_W-1:0] top
   );
      if (cur >= top) begin
         return '0;
      end
      return cur + 1'b1;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer, history flop,
// and a one-cycle rising-edge strobe per press.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic hist;

   // Resynchronize the raw level and keep one cycle of history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign rise = sync2 & ~hist;

endmodule

// File: rtl/sec_counter.sv
// Seconds timebase: 1 Hz prescaler, binary seconds count,
// and the STOP/RUN control driven by three push buttons.
module sec_counter
   import watch_pkg::*;
#(
   parameter int CLK_HZ    = CLK_HZ_DEF,
   parameter int MAX_COUNT = MAX_SEC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_run,
   input  logic             btn_clr,
   input  logic             btn_inc,
   output logic [SEC_W-1:0] sec,
   output logic             sec_tick,
   output logic             min_carry,
   output logic             running
);

   localparam int PW = $clog2(CLK_HZ);

   localparam logic [PW-1:0] P_LAST =
      PW'(CLK_HZ - 1);

   localparam logic [SEC_W-1:0] SEC_TOP =
      SEC_W'(MAX_COUNT);

   state_t           state;
   logic [PW-1:0]    presc;
   logic             run_e;
   logic             clr_e;
   logic             inc_e;
   logic             p_wrap;
   logic             sec_top;
   logic [SEC_W-1:0] sec_nx;

   btn_edge u_run (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_run),
      .rise (run_e)
   );

   btn_edge u_clr (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_clr),
      .rise (clr_e)
   );

   btn_edge u_inc (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_inc),
      .rise (inc_e)
   );

   assign p_wrap  = (state == RUN) && (presc == P_LAST);
   assign sec_top = (sec >= SEC_TOP);
   assign sec_nx  = sec_next(sec, SEC_TOP);

   // Control FSM, prescaler and seconds count with registered pulses;
   // clear outranks run toggle, which outranks manual increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= STOP;
         running   <= 1'b0;
         presc     <= '0;
         sec       <= '0;
         sec_tick  <= 1'b0;
         min_carry <= 1'b0;
      end else begin
         sec_tick  <= 1'b0;
         min_carry <= 1'b0;
         if (clr_e) begin
            state   <= STOP;
            running <= 1'b0;
            presc   <= '0;
            sec     <= '0;
         end else begin
            unique case (state)
               RUN: begin
                  if (p_wrap) begin
                     presc     <= '0;
                     sec       <= sec_nx;
                     sec_tick  <= 1'b1;
                     min_carry <= sec_top;
                  end else begin
                     presc <= presc + 1'b1;
                  end
                  if (run_e) begin
                     state   <= STOP;
                     running <= 1'b0;
                  end
               end
               STOP: begin
                  if (run_e) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end else if (inc_e) begin
                     sec <= sec_nx;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sec_counter.sv
// Scoreboard bench for sec_counter at CLK_HZ=4, MAX_COUNT=59.
// Stimulus queues expected output events; a monitor pops and compares.
module tb_sec_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_run = 1'b0;
   logic       btn_clr = 1'b0;
   logic       btn_inc = 1'b0;
   logic [7:0] sec;
   logic       sec_tick;
   logic       min_carry;
   logic       running;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] sec;
      logic       tick;
      logic       carry;
      logic       run;
      int         gap;
   } exp_t;

   exp_t q[$];

   sec_counter #(
      .CLK_HZ    (4),
      .MAX_COUNT (59)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_run   (btn_run),
      .btn_clr   (btn_clr),
      .btn_inc   (btn_inc),
      .sec       (sec),
      .sec_tick  (sec_tick),
      .min_carry (min_carry),
      .running   (running)
   );

   always #5 clk = ~clk;

   // gap < 0 means the spacing from the previous event is not checked
   task automatic push(input int s, input bit t, input bit c,
                       input bit r, input int g);
      exp_t e;
      e.sec   = 8'(s);
      e.tick  = t;
      e.carry = c;
      e.run   = r;
      e.gap   = g;
      q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_run++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic press_inc();
      btn_inc = 1'b1;
      cyc(1);
      btn_inc = 1'b0;
      cyc(3);
   endtask

   // Monitor: an event is any cycle where sec or running changed
   // or a pulse is high.
   logic [7:0] p_sec;
   logic       p_run;
   int         gap;
   exp_t       e;

   always @(negedge clk) begin
      if (!rst) begin
         p_sec = 8'd0;
         p_run = 1'b0;
         gap   = 0;
      end else begin
         gap++;
         if (sec != p_sec || running != p_run || sec_tick || min_carry) begin
            n_run++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: sec=%0d tick=%0b carry=%0b run=%0b",
                        sec, sec_tick, min_carry, running);
            end else begin
               e = q.pop_front();
               if (sec != e.sec || sec_tick != e.tick ||
                   min_carry != e.carry || running != e.run ||
                   (e.gap >= 0 && gap != e.gap)) begin
                  n_fail++;
                  $display("FAIL event: got sec=%0d tick=%0b carry=%0b run=%0b gap=%0d expected sec=%0d tick=%0b carry=%0b run=%0b gap=%0d",
                           sec, sec_tick, min_carry, running, gap,
                           e.sec, e.tick, e.carry, e.run, e.gap);
               end
            end
            gap   = 0;
            p_sec = sec;
            p_run = running;
         end
      end
   end

   initial begin
      cyc(3);
      chk("rst_sec", int'(sec), 0);
      chk("rst_run", int'(running), 0);
      chk("rst_tick", int'(sec_tick), 0);
      chk("rst_carry", int'(min_carry), 0);
      rst = 1'b1;
      cyc(2);

      // Run from 0 to 17 then reset asynchronously mid-count.
      push(0, 0, 0, 1, -1);
      for (int i = 1; i <= 17; i++) push(i, 1, 0, 1, 4);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(71);
      chk("pre_rst_sec", int'(sec), 17);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_sec", int'(sec), 0);
      chk("arst_run", int'(running), 0);
      chk("arst_tick", int'(sec_tick), 0);
      cyc(3);
      chk("arst_hold_sec", int'(sec), 0);
      chk("arst_hold_run", int'(running), 0);
      chk("arst_hold_tick", int'(sec_tick), 0);
      rst = 1'b1;
      cyc(2);

      // Run through the 59 -> 0 wrap, then stop with prescaler at 2.
      push(0, 0, 0, 1, -1);
      for (int i = 1; i <= 59; i++) push(i, 1, 0, 1, 4);
      push(0, 1, 1, 1, 4);
      push(1, 1, 0, 1, 4);
      push(1, 0, 0, 0, 2);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(245);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(20);
      chk("pause_sec", int'(sec), 1);
      chk("pause_run", int'(running), 0);

      // Resume: first tick two cycles after running rises.
      push(1, 0, 0, 1, -1);
      push(2, 1, 0, 1, 2);
      push(3, 1, 0, 1, 4);
      push(3, 0, 0, 0, 2);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(7);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(3);

      // Manual set up to 59, wrap to 0 without pulses, held button.
      for (int i = 4; i <= 59; i++) begin
         push(i, 0, 0, 0, -1);
         press_inc();
      end
      push(0, 0, 0, 0, -1);
      press_inc();
      push(1, 0, 0, 0, -1);
      btn_inc = 1'b1;
      cyc(10);
      btn_inc = 1'b0;
      cyc(3);
      chk("held_inc_sec", int'(sec), 1);
      for (int i = 2; i <= 28; i++) begin
         push(i, 0, 0, 0, -1);
         press_inc();
      end

      // Run from 28 with prescaler 2, ignore inc in RUN,
      // then clear+run+inc together at sec 30.
      push(28, 0, 0, 1, -1);
      push(29, 1, 0, 1, 2);
      push(30, 1, 0, 1, 4);
      push(0, 0, 0, 0, 2);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(4);
      btn_inc = 1'b1;
      cyc(1);
      btn_inc = 1'b0;
      cyc(2);
      btn_clr = 1'b1;
      btn_run = 1'b1;
      btn_inc = 1'b1;
      cyc(1);
      btn_clr = 1'b0;
      btn_run = 1'b0;
      btn_inc = 1'b0;
      cyc(5);
      chk("sim_sec", int'(sec), 0);
      chk("sim_run", int'(running), 0);

      // Prescaler was cleared: a full period to the first tick.
      push(0, 0, 0, 1, -1);
      push(1, 1, 0, 1, 4);
      push(0, 0, 0, 0, 3);
      btn_run = 1'b1;
      cyc(1);
      btn_run = 1'b0;
      cyc(6);
      btn_clr = 1'b1;
      cyc(1);
      btn_clr = 1'b0;
      cyc(10);

      chk("queue_left", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
